trojan0_cache_requester: RTL and testbench
==========================================

Name: trojan0_cache_requester

Overview:
Initiator side of the trojan0 cache access interface. Accepts one operation at a time from an upstream valid/ready port and drives the cache's addr_tag/addr_index/write_data/cache_read/cache_write pins using the cache's fixed IDLE→ACCESS→COMPLETE timing. Captures read_data/cache_hit on cache_ready, compares against an expected value, and keeps hit/miss/mismatch statistics. XOR corruption of read data by an embedded payload therefore shows up as mismatches.

Parameters:
DATA_WIDTH, 16, cache line data width
TAG_WIDTH, 4, cache tag width
TIMEOUT_CYCLES, 16, max WAIT cycles before cache_ready is declared missing
CNT_WIDTH, 16, width of statistics counters

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
op_valid  in  1  upstream operation valid
op_ready  out  1  high only in IDLE
op_write  in  1  1=write, 0=read
op_tag  in  TAG_WIDTH  tag
op_index  in  6  line index (passed through unmodified)
op_wdata  in  DATA_WIDTH  write data
op_check  in  1  compare read result to op_expect
op_expect  in  DATA_WIDTH  expected read data
addr_tag  out  TAG_WIDTH  to cache
addr_index  out  6  to cache
write_data  out  DATA_WIDTH  to cache
cache_read  out  1  to cache
cache_write  out  1  to cache
read_data  in  DATA_WIDTH  from cache
cache_hit  in  1  from cache (combinational lookup)
cache_ready  in  1  from cache completion pulse
rsp_valid  out  1  one-cycle response pulse
rsp_data  out  DATA_WIDTH  captured read data
rsp_hit  out  1  captured hit
rsp_mismatch  out  1  check failed
rsp_timeout  out  1  no cache_ready within TIMEOUT_CYCLES
clear_stats  in  1  zero all counters
hit_count, miss_count, mismatch_count  out  CNT_WIDTH each  saturating statistics

Behaviour:
- Reset (synchronous, active-high): state IDLE; all outputs 0 except op_ready=1; counters 0; latched op fields 0. Reset mid-operation drops cache_read/cache_write the next cycle; no response issued.
- States: IDLE, ISSUE, HOLD, WAIT.
- IDLE: op_valid & op_ready → latch all op_* fields → ISSUE.
- ISSUE → HOLD → WAIT unconditionally. cache_write = latched op_write, cache_read = ~latched op_write. Both are asserted only in ISSUE and HOLD, i.e. exactly 2 cycles.
- addr_tag/addr_index/write_data are driven from latched fields from ISSUE through the last WAIT cycle. In IDLE they hold their last values.
- WAIT: cache_ready=1 → register rsp_data=read_data and rsp_hit=cache_hit (both forced 0 for writes), pulse rsp_valid next cycle, → IDLE.
- Timeout: WAIT counter starts at 0. If TIMEOUT_CYCLES WAIT cycles pass without cache_ready → rsp_valid with rsp_timeout=1, rsp_data=0, rsp_hit=0, rsp_mismatch=op_check → IDLE.
- cache_ready in IDLE/ISSUE/HOLD is ignored.
- Latency: accept at cycle a; requests high a+1, a+2; cache_ready expected at a+4; rsp_valid at a+5. A new op may be accepted at a+5.
- rsp_mismatch = read & op_check & (~cache_hit | read_data≠op_expect). Writes never mismatch.
- Counters: reads only. Hit → hit_count+1; miss or timeout → miss_count+1. Any mismatch → mismatch_count+1. All counters saturate at all-ones. clear_stats has priority over an increment in the same cycle.
- op_index ≥ cache size: driven unchanged; the resulting miss is counted normally.

Decomposition:
- Package trojan0_cache_pkg: state enum (IDLE, ISSUE, HOLD, WAIT), default widths, request-hold constant = 2.
- One sub-module: trojan0_sat_counter (inc, clr, saturating, parameterised width), instantiated three times.

Test Plan:
1. Write tag=3 idx=2 data=0xA5A5 → cache_write high exactly cycles a+1..a+2, cache_read 0; rsp_valid at a+5, rsp_hit=0, rsp_mismatch=0, counters unchanged.
2. Read tag=3 idx=2, check, expect=0xA5A5, clean cache model → rsp_data=0xA5A5, rsp_hit=1, rsp_mismatch=0, hit_count=1.
3. Read tag=4 idx=2, check → rsp_hit=0, rsp_data=0, rsp_mismatch=1, miss_count=1, mismatch_count=1.
4. Cache model XORs read data with 0x0001, read expect=0xA5A5 → rsp_data=0xA5A4, rsp_hit=1, rsp_mismatch=1.
5. Cache model never asserts cache_ready → rsp_valid 16 cycles after WAIT entry, rsp_timeout=1, miss_count+1, op_ready=1 the next cycle.
6. rst asserted in HOLD → cache_read=0, op_ready=1, counters 0 next cycle, no rsp_valid. Also: 65536 read hits → hit_count stuck at 0xFFFF; clear_stats → 0.

Source files
------------

// File: rtl/trojan0_cache_pkg.sv
// rtl/trojan0_cache_pkg.sv - shared types and defaults for the trojan0 cache requester
package trojan0_cache_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2,
        WAIT  = 2'd3
    } req_state_t;

    localparam int DEF_DATA_WIDTH     = 16;
    localparam int DEF_TAG_WIDTH      = 4;
    localparam int DEF_TIMEOUT_CYCLES = 16;
    localparam int DEF_CNT_WIDTH      = 16;
    localparam int INDEX_WIDTH        = 6;
    // Cycles the cache needs cache_read/cache_write held (the ISSUE and HOLD states)
    localparam int REQ_HOLD_CYCLES    = 2;

endpackage

// File: rtl/trojan0_sat_counter.sv
// rtl/trojan0_sat_counter.sv - saturating up-counter with clear priority over increment
module trojan0_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/trojan0_cache_requester.sv
// rtl/trojan0_cache_requester.sv - single-outstanding initiator for the trojan0 cache interface
// Issues one op with fixed two-cycle request timing, checks read data, keeps hit/miss/mismatch stats.
module trojan0_cache_requester
    import trojan0_cache_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int TAG_WIDTH      = DEF_TAG_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int CNT_WIDTH      = DEF_CNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   op_valid,
    output logic                   op_ready,
    input  logic                   op_write,
    input  logic [TAG_WIDTH-1:0]   op_tag,
    input  logic [INDEX_WIDTH-1:0] op_index,
    input  logic [DATA_WIDTH-1:0]  op_wdata,
    input  logic                   op_check,
    input  logic [DATA_WIDTH-1:0]  op_expect,
    output logic [TAG_WIDTH-1:0]   addr_tag,
    output logic [INDEX_WIDTH-1:0] addr_index,
    output logic [DATA_WIDTH-1:0]  write_data,
    output logic                   cache_read,
    output logic                   cache_write,
    input  logic [DATA_WIDTH-1:0]  read_data,
    input  logic                   cache_hit,
    input  logic                   cache_ready,
    output logic                   rsp_valid,
    output logic [DATA_WIDTH-1:0]  rsp_data,
    output logic                   rsp_hit,
    output logic                   rsp_mismatch,
    output logic                   rsp_timeout,
    input  logic                   clear_stats,
    output logic [CNT_WIDTH-1:0]   hit_count,
    output logic [CNT_WIDTH-1:0]   miss_count,
    output logic [CNT_WIDTH-1:0]   mismatch_count
);

    localparam int WCNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT_CYCLES - 1);

    req_state_t             state;
    logic                   op_write_q;
    logic                   op_check_q;
    logic [DATA_WIDTH-1:0]  op_expect_q;
    logic [WCNT_W-1:0]      wait_cnt;

    logic wait_done;
    logic wait_expire;
    logic rd_mismatch;
    logic hit_inc;
    logic miss_inc;
    logic mismatch_inc;

    always_comb begin
        wait_done    = (state == WAIT) && cache_ready;
        wait_expire  = (state == WAIT) && !cache_ready && (wait_cnt == WCNT_LAST);
        rd_mismatch  = op_check_q && (!cache_hit || (read_data != op_expect_q));
        hit_inc      = !op_write_q && wait_done && cache_hit;
        miss_inc     = !op_write_q && ((wait_done && !cache_hit) || wait_expire);
        // A timed-out checked read has no data to compare, so it counts as a mismatch
        mismatch_inc = !op_write_q && ((wait_done && rd_mismatch) || (wait_expire && op_check_q));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            op_ready     <= 1'b1;
            op_write_q   <= 1'b0;
            op_check_q   <= 1'b0;
            op_expect_q  <= '0;
            wait_cnt     <= '0;
            addr_tag     <= '0;
            addr_index   <= '0;
            write_data   <= '0;
            cache_read   <= 1'b0;
            cache_write  <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_data     <= '0;
            rsp_hit      <= 1'b0;
            rsp_mismatch <= 1'b0;
            rsp_timeout  <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (op_valid && op_ready) begin
                        op_write_q  <= op_write;
                        op_check_q  <= op_check;
                        op_expect_q <= op_expect;
                        addr_tag    <= op_tag;
                        addr_index  <= op_index;
                        write_data  <= op_wdata;
                        cache_write <= op_write;
                        cache_read  <= !op_write;
                        op_ready    <= 1'b0;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= HOLD;
                end
                HOLD: begin
                    cache_read  <= 1'b0;
                    cache_write <= 1'b0;
                    wait_cnt    <= '0;
                    state       <= WAIT;
                end
                WAIT: begin
                    if (cache_ready) begin
                        rsp_valid    <= 1'b1;
                        rsp_data     <= op_write_q ? '0 : read_data;
                        rsp_hit      <= !op_write_q && cache_hit;
                        rsp_mismatch <= !op_write_q && rd_mismatch;
                        rsp_timeout  <= 1'b0;
                        op_ready     <= 1'b1;
                        state        <= IDLE;
                    end else if (wait_cnt == WCNT_LAST) begin
                        rsp_valid    <= 1'b1;
                        rsp_data     <= '0;
                        rsp_hit      <= 1'b0;
                        rsp_mismatch <= !op_write_q && op_check_q;
                        rsp_timeout  <= 1'b1;
                        op_ready     <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    trojan0_sat_counter #(.WIDTH(CNT_WIDTH)) u_hit_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clear_stats),
        .inc   (hit_inc),
        .count (hit_count)
    );

    trojan0_sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clear_stats),
        .inc   (miss_inc),
        .count (miss_count)
    );

    trojan0_sat_counter #(.WIDTH(CNT_WIDTH)) u_mismatch_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clear_stats),
        .inc   (mismatch_inc),
        .count (mismatch_count)
    );

endmodule

// File: tb/tb_trojan0_cache_requester.sv
// tb/tb_trojan0_cache_requester.sv - directed self-checking bench for trojan0_cache_requester
// Counters are built 8 bits wide here so saturation is reachable in a short run.
module tb_trojan0_cache_requester;

    localparam int DW = 16;
    localparam int TW = 4;
    localparam int TO = 16;
    localparam int CW = 8;

    logic          clk;
    logic          rst;
    logic          op_valid;
    logic          op_ready;
    logic          op_write;
    logic [TW-1:0] op_tag;
    logic [5:0]    op_index;
    logic [DW-1:0] op_wdata;
    logic          op_check;
    logic [DW-1:0] op_expect;
    logic [TW-1:0] addr_tag;
    logic [5:0]    addr_index;
    logic [DW-1:0] write_data;
    logic          cache_read;
    logic          cache_write;
    logic [DW-1:0] read_data;
    logic          cache_hit;
    logic          cache_ready;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          rsp_hit;
    logic          rsp_mismatch;
    logic          rsp_timeout;
    logic          clear_stats;
    logic [CW-1:0] hit_count;
    logic [CW-1:0] miss_count;
    logic [CW-1:0] mismatch_count;

    trojan0_cache_requester #(
        .DATA_WIDTH(DW), .TAG_WIDTH(TW), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .op_valid(op_valid), .op_ready(op_ready), .op_write(op_write),
        .op_tag(op_tag), .op_index(op_index), .op_wdata(op_wdata),
        .op_check(op_check), .op_expect(op_expect),
        .addr_tag(addr_tag), .addr_index(addr_index), .write_data(write_data),
        .cache_read(cache_read), .cache_write(cache_write),
        .read_data(read_data), .cache_hit(cache_hit), .cache_ready(cache_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_hit(rsp_hit),
        .rsp_mismatch(rsp_mismatch), .rsp_timeout(rsp_timeout),
        .clear_stats(clear_stats),
        .hit_count(hit_count), .miss_count(miss_count), .mismatch_count(mismatch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cache model: 64 direct-mapped lines, ready pulse three cycles after the request rises
    logic [TW-1:0] tag_mem  [64];
    logic [DW-1:0] data_mem [64];
    logic          vld_mem  [64];
    logic          ready_en;
    logic [DW-1:0] xor_mask;
    logic          req_d;
    logic          busy;
    logic [1:0]    mcnt;

    assign cache_hit = vld_mem[addr_index] && (tag_mem[addr_index] == addr_tag);
    assign read_data = cache_hit ? (data_mem[addr_index] ^ xor_mask) : '0;

    always @(posedge clk) begin
        if (rst) begin
            req_d       <= 1'b0;
            busy        <= 1'b0;
            mcnt        <= 2'd0;
            cache_ready <= 1'b0;
            for (int i = 0; i < 64; i++) vld_mem[i] <= 1'b0;
        end else begin
            req_d       <= cache_read | cache_write;
            cache_ready <= 1'b0;
            if ((cache_read || cache_write) && !req_d) begin
                busy <= 1'b1;
                mcnt <= 2'd1;
                if (cache_write) begin
                    vld_mem[addr_index]  <= 1'b1;
                    tag_mem[addr_index]  <= addr_tag;
                    data_mem[addr_index] <= write_data;
                end
            end else if (busy) begin
                if (mcnt == 2'd2) begin
                    busy        <= 1'b0;
                    cache_ready <= ready_en;
                end else begin
                    mcnt <= mcnt + 2'd1;
                end
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    int lat;
    int rd_cyc;
    int wr_cyc;
    int first_req;
    int idx_seen;

    // Called just after a negedge; returns after the negedge where rsp_valid is seen
    task do_op(input logic w, input logic [TW-1:0] tg, input logic [5:0] idx,
               input logic [DW-1:0] wd, input logic chk, input logic [DW-1:0] ex);
        int n;
        lat = -1; rd_cyc = 0; wr_cyc = 0; first_req = -1; idx_seen = -1;
        op_write = w; op_tag = tg; op_index = idx; op_wdata = wd;
        op_check = chk; op_expect = ex; op_valid = 1'b1;
        @(posedge clk);
        #1 op_valid = 1'b0;
        op_tag = '0; op_index = '0; op_wdata = '0; op_expect = '0;
        n = 0;
        while (n < 40) begin
            n++;
            @(negedge clk);
            if (n == 1) idx_seen = int'(addr_index);
            if (cache_read)  rd_cyc++;
            if (cache_write) wr_cyc++;
            if ((cache_read || cache_write) && first_req < 0) first_req = n;
            if (rsp_valid) begin
                lat = n;
                break;
            end
        end
    endtask

    int pulses;

    initial begin
        rst = 1'b1; op_valid = 1'b0; op_write = 1'b0; op_tag = '0; op_index = '0;
        op_wdata = '0; op_check = 1'b0; op_expect = '0; clear_stats = 1'b0;
        ready_en = 1'b1; xor_mask = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_op_ready", op_ready, 1);
        check_eq("rst_cache_rd", cache_read, 0);
        check_eq("rst_cache_wr", cache_write, 0);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_hit_cnt", hit_count, 0);
        check_eq("rst_addr_tag", addr_tag, 0);
        rst = 1'b0;

        // 1: write
        do_op(1'b1, 4'd3, 6'd2, 16'hA5A5, 1'b0, 16'h0000);
        check_eq("t1_lat", lat, 5);
        check_eq("t1_wr_cyc", wr_cyc, 2);
        check_eq("t1_first_req", first_req, 1);
        check_eq("t1_rd_cyc", rd_cyc, 0);
        check_eq("t1_idx", idx_seen, 2);
        check_eq("t1_hit", rsp_hit, 0);
        check_eq("t1_mm", rsp_mismatch, 0);
        check_eq("t1_addr_hold", addr_tag, 3);
        check_eq("t1_counts", {hit_count, miss_count, mismatch_count}, 0);

        // 2: clean read hit, issued back-to-back with the previous response
        do_op(1'b0, 4'd3, 6'd2, 16'h0000, 1'b1, 16'hA5A5);
        check_eq("t2_lat", lat, 5);
        check_eq("t2_rd_cyc", rd_cyc, 2);
        check_eq("t2_data", rsp_data, 16'hA5A5);
        check_eq("t2_hit", rsp_hit, 1);
        check_eq("t2_mm", rsp_mismatch, 0);
        check_eq("t2_hit_cnt", hit_count, 1);

        // 3: tag miss
        do_op(1'b0, 4'd4, 6'd2, 16'h0000, 1'b1, 16'hA5A5);
        check_eq("t3_hit", rsp_hit, 0);
        check_eq("t3_data", rsp_data, 0);
        check_eq("t3_mm", rsp_mismatch, 1);
        check_eq("t3_miss_cnt", miss_count, 1);
        check_eq("t3_mm_cnt", mismatch_count, 1);

        // 4: corrupted read data
        xor_mask = 16'h0001;
        do_op(1'b0, 4'd3, 6'd2, 16'h0000, 1'b1, 16'hA5A5);
        check_eq("t4_data", rsp_data, 16'hA5A4);
        check_eq("t4_hit", rsp_hit, 1);
        check_eq("t4_mm", rsp_mismatch, 1);
        check_eq("t4_hit_cnt", hit_count, 2);
        check_eq("t4_mm_cnt", mismatch_count, 2);
        xor_mask = '0;

        // 5: no cache_ready -> timeout, WAIT entered at cycle 3, response 16 cycles later
        ready_en = 1'b0;
        do_op(1'b0, 4'd3, 6'd63, 16'h0000, 1'b1, 16'hA5A5);
        check_eq("t5_lat", lat, 19);
        check_eq("t5_idx", idx_seen, 63);
        check_eq("t5_timeout", rsp_timeout, 1);
        check_eq("t5_data", rsp_data, 0);
        check_eq("t5_mm", rsp_mismatch, 1);
        check_eq("t5_miss_cnt", miss_count, 2);
        check_eq("t5_mm_cnt", mismatch_count, 3);
        @(negedge clk);
        check_eq("t5_ready_after", op_ready, 1);
        check_eq("t5_rsp_drop", rsp_valid, 0);
        ready_en = 1'b1;

        // 6: reset while in HOLD
        op_write = 1'b0; op_tag = 4'd3; op_index = 6'd2; op_check = 1'b1;
        op_expect = 16'hA5A5; op_valid = 1'b1;
        @(posedge clk);
        #1 op_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check_eq("t6_hold_rd", cache_read, 1);
        @(negedge clk);
        rst = 1'b0;
        check_eq("t6_cache_rd", cache_read, 0);
        check_eq("t6_op_ready", op_ready, 1);
        check_eq("t6_counts", {hit_count, miss_count, mismatch_count}, 0);
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid) pulses++;
        end
        check_eq("t6_no_rsp", pulses, 0);

        // clear_stats wins over a simultaneous increment
        do_op(1'b1, 4'd5, 6'd7, 16'h1234, 1'b0, 16'h0000);
        do_op(1'b0, 4'd5, 6'd7, 16'h0000, 1'b1, 16'h1234);
        check_eq("clr_pre_hit", hit_count, 1);
        clear_stats = 1'b1;
        do_op(1'b0, 4'd5, 6'd7, 16'h0000, 1'b1, 16'h1234);
        check_eq("clr_rsp_hit", rsp_hit, 1);
        check_eq("clr_prio_hit", hit_count, 0);
        clear_stats = 1'b0;

        // saturation
        for (int i = 0; i < 255; i++) do_op(1'b0, 4'd5, 6'd7, 16'h0000, 1'b1, 16'h1234);
        check_eq("sat_reach", hit_count, 8'hFF);
        check_eq("sat_lat", lat, 5);
        for (int i = 0; i < 2; i++) do_op(1'b0, 4'd5, 6'd7, 16'h0000, 1'b1, 16'h1234);
        check_eq("sat_stuck", hit_count, 8'hFF);
        check_eq("sat_miss", miss_count, 0);
        clear_stats = 1'b1;
        @(posedge clk);
        #1 clear_stats = 1'b0;
        @(negedge clk);
        check_eq("sat_clear", hit_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
